// File: rtl/status_beacon.sv
// Wishbone-programmed status driver: queues stage codes and shows each on the
// GPIO pins for a guaranteed dwell so a slow-sampling monitor sees every code.
module status_beacon #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DWELL     = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [5:0]  io_out,
  output logic [5:0]  io_oeb
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W  = $clog2(DWELL + 1);
  localparam int unsigned CODE_W = 5;

  localparam logic [1:0] OFF_STAGE  = 2'd0;
  localparam logic [1:0] OFF_ERROR  = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic [10:0]       rsv_hi;
    logic [CODE_W-1:0] code;
    logic [2:0]        rsv_mid;
    logic              error;
    logic              overflow;
    logic              busy;
    logic              empty;
    logic              full;
    logic [7:0]        level;
  } status_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [CODE_W-1:0]  display;
  logic [CODE_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               error;
  logic               overflow;

  logic               addr_hit_c;
  logic               accept_c;
  logic [1:0]         offset_c;
  logic               stage_wr_c;
  logic               error_set_c;
  logic               status_rd_c;
  logic               full_c;
  logic               empty_c;
  logic               push_c;
  logic               pop_c;
  status_t            status_c;
  logic               unused_bits;

  // Bus decode: a single-cycle accept guarded by the registered ack.
  assign addr_hit_c  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign accept_c    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & addr_hit_c;
  assign offset_c    = wbs_adr_i[3:2];
  assign stage_wr_c  = accept_c & wbs_we_i & (offset_c == OFF_STAGE);
  assign error_set_c = accept_c & wbs_we_i & (offset_c == OFF_ERROR) & wbs_dat_i[0];
  assign status_rd_c = accept_c & ~wbs_we_i & (offset_c == OFF_STATUS);

  assign full_c  = (level == LVL_W'(DEPTH));
  assign empty_c = (level == '0);
  assign push_c  = stage_wr_c & ~full_c;

  assign unused_bits = &{1'b0, wbs_adr_i[1:0], wbs_dat_i[31:CODE_W]};

  // Display sequencer: pop a code, hold it DWELL cycles, repeat while queued.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty_c) begin
          pop_c      = 1'b1;
          cnt_next   = CNT_W'(DWELL - 1);
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else if (!empty_c) begin
          pop_c    = 1'b1;
          cnt_next = CNT_W'(DWELL - 1);
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      display <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (pop_c) begin
        display <= mem[rd_ptr];
      end
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and level.
  always_ff @(posedge wb_clk_i) begin
    if (push_c) begin
      mem[wr_ptr] <= wbs_dat_i[CODE_W-1:0];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky flags, cleared only by reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      error    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (error_set_c) begin
        error <= 1'b1;
      end
      if (stage_wr_c && full_c) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    status_c          = '0;
    status_c.level    = 8'(level);
    status_c.full     = full_c;
    status_c.empty    = empty_c;
    status_c.busy     = (state == S_HOLD);
    status_c.overflow = overflow;
    status_c.error    = error;
    status_c.code     = display;
  end

  // Read data is only non-zero alongside the ack of a STATUS read.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= accept_c;
      wbs_dat_o <= status_rd_c ? status_c : '0;
    end
  end

  assign io_out = {error, display};
  assign io_oeb = '0;

endmodule

// File: tb/tb_status_beacon.sv
// Self-checking bench for status_beacon: display scoreboard plus directed
// register, overflow, error and reset scenarios.
module tb_status_beacon;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DWELL = 16;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat;
  logic        ack;
  logic [31:0] dat_o;
  logic [5:0]  io_out;
  logic [5:0]  io_oeb;

  typedef struct packed {
    logic [4:0] code;
    logic       chk_dwell;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;

  status_beacon #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DWELL(DWELL)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .io_out    (io_out),
    .io_oeb    (io_oeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Display monitor: every code change must match the next queued expectation.
  logic [4:0] prev_disp;
  int         since;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_disp = '0;
      since     = 0;
    end else if (io_out[4:0] !== prev_disp) begin
      check("disp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("disp_code", 32'(io_out[4:0]), 32'(mon_e.code));
        if (mon_e.chk_dwell) check("dwell", 32'(since), 32'(DWELL));
      end
      prev_disp = io_out[4:0];
      since     = 1;
    end else begin
      since++;
    end
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rdat, output logic acked);
    @(posedge clk); #1;
    check("ack_idle", 32'(ack), 32'd0);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d;
    acked = 1'b0;
    rdat  = '0;
    for (int i = 0; i < 4; i++) begin
      if (!acked) begin
        @(posedge clk); #1;
        if (ack) begin
          acked = 1'b1;
          rdat  = dat_o;
        end
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    logic [31:0] r;
    logic        a;
    wb_xfer(1'b1, BASE + 32'(off) * 32'd4, d, r, a);
    check("wr_ack", 32'(a), 32'd1);
  endtask

  task automatic rd(input string tag, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] r;
    logic        a;
    wb_xfer(1'b0, BASE + 32'(off) * 32'd4, 32'd0, r, a);
    check({tag, "_ack"}, 32'(a), 32'd1);
    check(tag, r, exp);
  endtask

  task automatic stage(input logic [4:0] code, input logic chk);
    exp_t e;
    e.code      = code;
    e.chk_dwell = chk;
    exp_q.push_back(e);
    wr(2'd0, 32'(code));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("rst_io_out", 32'(io_out), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < int'(DWELL * (DEPTH + 2) * 2); i++) begin
      if (exp_q.size() != 0) @(posedge clk);
    end
    @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic        a;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_io_out", 32'(io_out), 32'd0);
    check("reset_io_oeb", 32'(io_oeb), 32'd0);
    check("reset_dat_o", dat_o, 32'd0);
    rst = 1'b0;
    rd("status_reset", 2'd2, 32'h0000_0200);

    // Single code: visible one edge after acceptance, busy for DWELL cycles.
    stage(5'd31, 1'b0);
    @(posedge clk); #1;
    check("single_io_out", 32'(io_out), 32'h1F);
    rd("status_busy", 2'd2, 32'h001F_0600);
    repeat (DWELL) @(posedge clk);
    rd("status_idle", 2'd2, 32'h001F_0200);
    check("single_held", 32'(io_out), 32'h1F);

    // Back-to-back codes are each shown exactly DWELL cycles, in order.
    do_reset();
    stage(5'd31, 1'b0);
    stage(5'd5, 1'b1);
    stage(5'd30, 1'b1);
    wait_drain();
    repeat (DWELL + 2) @(posedge clk);
    #1;
    check("b2b_final", 32'(io_out), 32'h1E);

    // Overflow: code 6 is dropped while 2..5 fill the queue.
    do_reset();
    stage(5'd1, 1'b0);
    for (int c = 2; c <= 5; c++) stage(5'(c), 1'b1);
    wr(2'd0, 32'd6);
    rd("status_full", 2'd2, 32'h0001_0D04);
    wait_drain();
    repeat (DWELL + 4) @(posedge clk);
    rd("status_ovf", 2'd2, 32'h0005_0A00);
    check("ovf_final", 32'(io_out), 32'h05);

    // Sticky error, independent of the stage queue.
    do_reset();
    wr(2'd1, 32'd1);
    check("err_set", 32'(io_out[5]), 32'd1);
    stage(5'd30, 1'b0);
    wait_drain();
    check("err_io_out", 32'(io_out), 32'h3E);
    wr(2'd1, 32'd0);
    check("err_sticky", 32'(io_out), 32'h3E);
    repeat (DWELL + 2) @(posedge clk);
    rd("status_err", 2'd2, 32'h001E_1200);
    rd("read_stage", 2'd0, 32'd0);
    rd("read_rsvd", 2'd3, 32'd0);
    wr(2'd3, 32'h1F);
    wr(2'd2, 32'hFFFF_FFFF);
    rd("status_after_ign", 2'd2, 32'h001E_1200);

    // Reset mid-hold drops the display and the queued codes.
    do_reset();
    stage(5'd5, 1'b0);
    wr(2'd0, 32'd2);
    wr(2'd0, 32'd7);
    @(posedge clk); #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midhold_io_out", 32'(io_out), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd("status_after_rst", 2'd2, 32'h0000_0200);

    // Reset during a pending ack suppresses it; the pushed code is lost.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; dat = 32'd9;
    @(posedge clk); #1;
    check("pre_rst_ack", 32'(ack), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_kills_ack", 32'(ack), 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Wrong base address: no ack and no effect.
    wb_xfer(1'b1, 32'h4000_0000, 32'd3, r, a);
    check("bad_base_ack", 32'(a), 32'd0);
    repeat (2 * DWELL) @(posedge clk);
    #1;
    check("final_io_out", 32'(io_out), 32'd0);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/status_beacon.md
# status_beacon

Wishbone-attached test-status driver inside the user project: firmware writes stage codes and error events, and the block presents them on six GPIO outputs (bit 5 error, bits 4:0 stage). The harness monitor samples these pins only every 100 clocks. Each stage code is therefore queued and held for a guaranteed dwell time, so every code is visible to the monitor in write order. It drives the status pins that the top-level harness watches.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: Wishbone base address; match on `wbs_adr_i[31:4]`.
- `DEPTH`, default 4: stage FIFO depth, power of two, ≥2.
- `DWELL`, default 256: minimum cycles each popped code is displayed, ≥1; counter width clog2(DWELL+1).

Ports:
- `wb_clk_i` in 1: sole clock, rising edge.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `wbs_cyc_i` in 1: Wishbone cycle.
- `wbs_stb_i` in 1: Wishbone strobe.
- `wbs_we_i` in 1: write enable.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: acknowledge.
- `wbs_dat_o` out 32: read data.
- `io_out` out 6: {error, stage[4:0]}.
- `io_oeb` out 6: output enables, active low; constant 0.

## Operation
- Register map, offset = `wbs_adr_i[3:2]`:
  - 0 STAGE, W: push `wbs_dat_i[4:0]`.
  - 1 ERROR, W: if `wbs_dat_i[0]`, set sticky error.
  - 2 STATUS, R: [7:0] FIFO level; [8] full; [9] empty; [10] busy (HOLD); [11] overflow; [12] error; [20:16] displayed code; others 0.
  - 3: reserved; reads return 0, writes ignored.
- Reads of STAGE/ERROR return 0. Writes to STATUS are ignored.
- Access accepted at an edge where `cyc&stb&!ack` and the address matches. Non-matching addresses get no ack.
- FIFO push at the accepting edge. If the FIFO is full, the write is dropped, overflow is set sticky, and ack is still given. Fullness is evaluated before any same-edge pop, so a push while full is dropped even if a pop occurs on that edge.
- FSM:
  - IDLE: displayed code held. If FIFO non-empty, pop into the display register, load counter = DWELL-1, go to HOLD.
  - HOLD: decrement counter each cycle. When counter = 0: if FIFO non-empty, pop next and reload counter (stay in HOLD); else go to IDLE.
  - Each code is displayed exactly DWELL cycles when followed by another code. The last code is held indefinitely.
- Error: sticky, set on the accepting edge of an ERROR write with bit0 = 1. Independent of the FIFO and FSM. Cleared only by reset.
- Overflow: sticky, cleared only by reset.
- `io_out = {error, display}`.

## Timing
- Reset values: `io_out`=0, `io_oeb`=0, `wbs_ack_o`=0, `wbs_dat_o`=0; FIFO empty; level=0; FSM IDLE; counter=0; error=0; overflow=0.
- Ack is registered: high the cycle after acceptance, for exactly one cycle. A strobe still high while ack is high is not re-accepted.
- `wbs_dat_o` is registered, valid with ack, and 0 otherwise.
- STAGE write into an empty FIFO in IDLE: pushed at edge N, popped at edge N+1, so `io_out` changes after edge N+1.
- ERROR write: `io_out[5]`=1 after the accepting edge.
- A STATUS read reflects state before the accepting edge.
- Reset asserted mid-HOLD or mid-transaction returns every register to its reset value immediately, with no ack. Queued codes are lost.

## Test plan
- Reset release, no access -> `io_out`=6'h00, `io_oeb`=0; STATUS read = 0x0000_0200 (empty).
- Write STAGE=31 -> ack one cycle later; `io_out`=6'h1F one edge after acceptance and held indefinitely; STATUS busy=1 for DWELL cycles, then 0.
- Back-to-back writes 31, 5, 30 -> `io_out` shows 0x1F, 0x05, 0x1E, each for exactly DWELL cycles (first two), in order; 0x1E remains.
- With DEPTH=4, during a hold write 6 codes (1..6) -> 1 displayed; 2..5 queued; 6 dropped; STATUS overflow=1, full=1; display sequence is 1, 2, 3, 4, 5 only.
- Write ERROR=1 then STAGE=30 -> `io_out[5]`=1 from the edge after acceptance and stays 1; `io_out` ends at 6'h3E. ERROR=0 write leaves error at 1.
- Assert reset while holding code 5 with 2 queued -> `io_out`=0 immediately; after release, STATUS reads 0x0000_0200. Wrong-base address access -> no ack.
